memory_port_arbiter: RTL and testbench

Sequential arbiter that shares the single-ported `memory_system_wrapper` port between two requesters:

- **Instruction fetch**: read-only.
- **Data access**: load/store.

It sits between the core's fetch/LSU logic and the memory system. It performs round-robin arbitration, latches the winning request, drives the memory port for the configured read latency and returns a one-cycle acknowledge with data. It rejects misaligned, unmapped and ROM-write accesses without touching memory.

---
 rtl/memory_arbiter_pkg.sv | 24 ++
 rtl/address_range_checker.sv | 30 +++
 rtl/memory_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_memory_port_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types and address map for the memory port arbiter.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_ROM  = 2'd1,
        REGION_RAM  = 2'd2
    } region_e;

    localparam logic [31:0] ROM_BASE = 32'h0040_0000;
    localparam logic [31:0] RAM_BASE = 32'h1001_0000;

endpackage

// File: rtl/address_range_checker.sv
// Classifies a byte address into ROM/RAM/unmapped and flags illegal accesses
// (misaligned, unmapped, or a store into ROM).
module address_range_checker
    import memory_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 32
) (
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    output logic                  legal_o,
    output region_e               region_o
);

    localparam logic [DATA_WIDTH-1:0] SPAN   = DATA_WIDTH'(4 * MEMORY_DEPTH);
    localparam logic [DATA_WIDTH-1:0] ROM_LO = DATA_WIDTH'(ROM_BASE);
    localparam logic [DATA_WIDTH-1:0] RAM_LO = DATA_WIDTH'(RAM_BASE);

    // Offset compare keeps the upper bound from overflowing near the top of the map.
    always_comb begin
        region_o = REGION_NONE;
        if (addr_i >= ROM_LO && (addr_i - ROM_LO) < SPAN)
            region_o = REGION_ROM;
        else if (addr_i >= RAM_LO && (addr_i - RAM_LO) < SPAN)
            region_o = REGION_RAM;
        legal_o = (addr_i[1:0] == 2'b00) &&
                  ((region_o == REGION_RAM) || (region_o == REGION_ROM && !we_i));
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch
// and data load/store; illegal requests are answered without touching memory.
module memory_port_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_i,
    input  logic [DATA_WIDTH-1:0] if_addr_i,
    output logic                  if_ack_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_err_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [DATA_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_ack_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_err_o,
    output logic [DATA_WIDTH-1:0] mem_address_o,
    output logic                  mem_write_enable_o,
    output logic [DATA_WIDTH-1:0] mem_write_data_o,
    input  logic [DATA_WIDTH-1:0] mem_read_data_i
);

    localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

    arb_state_e            state_q, state_d;
    req_id_e               last_grant_q, last_grant_d;
    req_id_e               gnt_id_q, gnt_id_d;
    logic                  we_q, we_d;
    logic [2:0]            lat_cnt_q, lat_cnt_d;

    logic                  if_ack_q, if_ack_d, if_err_q, if_err_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic                  d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;

    req_id_e               pick;
    logic [DATA_WIDTH-1:0] pick_addr;
    logic                  pick_we, pick_legal;
    region_e               pick_region;
    logic [DATA_WIDTH-1:0] resp_data;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        if (if_req_i && d_req_i)
            pick = (last_grant_q == REQ_D) ? REQ_IF : REQ_D;
        else
            pick = if_req_i ? REQ_IF : REQ_D;
        pick_addr = (pick == REQ_IF) ? if_addr_i : d_addr_i;
        pick_we   = (pick == REQ_D) && d_we_i;
    end

    address_range_checker #(
        .DATA_WIDTH   (DATA_WIDTH),
        .MEMORY_DEPTH (MEMORY_DEPTH)
    ) u_checker (
        .addr_i   (pick_addr),
        .we_i     (pick_we),
        .legal_o  (pick_legal),
        .region_o (pick_region)
    );

    assign resp_data = we_q ? '0 : mem_read_data_i;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        we_d         = we_q;
        lat_cnt_d    = lat_cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        if_ack_d     = 1'b0;
        if_err_d     = 1'b0;
        if_rdata_d   = '0;
        d_ack_d      = 1'b0;
        d_err_d      = 1'b0;
        d_rdata_d    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (if_req_i || d_req_i) begin
                    gnt_id_d     = pick;
                    last_grant_d = pick;
                    we_d         = pick_we;
                    lat_cnt_d    = '0;
                    if (pick_legal) begin
                        state_d    = ST_ACCESS;
                        mem_addr_d = pick_addr;
                        mem_we_d   = pick_we;
                        if (pick_we && pick_region == REGION_RAM)
                            mem_wdata_d = d_wdata_i;
                    end else begin
                        // Rejected: answer straight away, memory port untouched.
                        state_d = ST_RESP;
                        if (pick == REQ_IF) begin
                            if_ack_d = 1'b1;
                            if_err_d = 1'b1;
                        end else begin
                            d_ack_d = 1'b1;
                            d_err_d = 1'b1;
                        end
                    end
                end
            end
            ST_ACCESS: begin
                if (we_q || lat_cnt_q == LAT_LAST) begin
                    state_d = ST_RESP;
                    if (gnt_id_q == REQ_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = resp_data;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = resp_data;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= REQ_D;
            gnt_id_q     <= REQ_IF;
            we_q         <= 1'b0;
            lat_cnt_q    <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            if_ack_q     <= 1'b0;
            if_err_q     <= 1'b0;
            if_rdata_q   <= '0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            we_q         <= we_d;
            lat_cnt_q    <= lat_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            if_ack_q     <= if_ack_d;
            if_err_q     <= if_err_d;
            if_rdata_q   <= if_rdata_d;
            d_ack_q      <= d_ack_d;
            d_err_q      <= d_err_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign if_ack_o           = if_ack_q;
    assign if_err_o           = if_err_q;
    assign if_rdata_o         = if_rdata_q;
    assign d_ack_o            = d_ack_q;
    assign d_err_o            = d_err_q;
    assign d_rdata_o          = d_rdata_q;
    assign mem_address_o      = mem_addr_q;
    assign mem_write_enable_o = mem_we_q;
    assign mem_write_data_o   = mem_wdata_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench: two arbiters (read latency 1 and 3) on behavioural memories, checked
// against an address-map / latency reference model.
module tb_memory_port_arbiter;

    localparam logic [31:0] ROM_B = 32'h0040_0000;
    localparam logic [31:0] RAM_B = 32'h1001_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        a_if_req = 0, a_d_req = 0, a_d_we = 0;
    logic [31:0] a_if_addr = 0, a_d_addr = 0, a_d_wdata = 0;
    logic        a_if_ack, a_if_err, a_d_ack, a_d_err, a_mwe;
    logic [31:0] a_if_rdata, a_d_rdata, a_maddr, a_mwdata, a_mrdata;

    logic        b_d_req = 0, b_d_we = 0;
    logic [31:0] b_d_addr = 0, b_d_wdata = 0;
    logic        b_if_ack, b_if_err, b_d_ack, b_d_err, b_mwe;
    logic [31:0] b_if_rdata, b_d_rdata, b_maddr, b_mwdata, b_mrdata;
    logic        b_if_req = 0;
    logic [31:0] b_if_addr = 0;

    memory_port_arbiter #(.DATA_WIDTH(32), .MEMORY_DEPTH(32), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset),
        .if_req_i(a_if_req), .if_addr_i(a_if_addr), .if_ack_o(a_if_ack),
        .if_rdata_o(a_if_rdata), .if_err_o(a_if_err),
        .d_req_i(a_d_req), .d_we_i(a_d_we), .d_addr_i(a_d_addr), .d_wdata_i(a_d_wdata),
        .d_ack_o(a_d_ack), .d_rdata_o(a_d_rdata), .d_err_o(a_d_err),
        .mem_address_o(a_maddr), .mem_write_enable_o(a_mwe),
        .mem_write_data_o(a_mwdata), .mem_read_data_i(a_mrdata)
    );

    memory_port_arbiter #(.DATA_WIDTH(32), .MEMORY_DEPTH(32), .READ_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset),
        .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_ack_o(b_if_ack),
        .if_rdata_o(b_if_rdata), .if_err_o(b_if_err),
        .d_req_i(b_d_req), .d_we_i(b_d_we), .d_addr_i(b_d_addr), .d_wdata_i(b_d_wdata),
        .d_ack_o(b_d_ack), .d_rdata_o(b_d_rdata), .d_err_o(b_d_err),
        .mem_address_o(b_maddr), .mem_write_enable_o(b_mwe),
        .mem_write_data_o(b_mwdata), .mem_read_data_i(b_mrdata)
    );

    function automatic logic [31:0] rom_word(input logic [4:0] i);
        return 32'hA000_0000 | {27'd0, i};
    endfunction

    // Behavioural memories
    logic [31:0] ram_a [32];
    logic [31:0] ram_b [32];
    logic [31:0] b_look, b_p1, b_p2;
    initial for (int i = 0; i < 32; i++) begin ram_a[i] = 0; ram_b[i] = 0; end

    always_comb begin
        a_mrdata = 32'hDEAD_BEEF;
        if (a_maddr[31:7] == ROM_B[31:7]) a_mrdata = rom_word(a_maddr[6:2]);
        else if (a_maddr[31:7] == RAM_B[31:7]) a_mrdata = ram_a[a_maddr[6:2]];
    end
    always_comb begin
        b_look = 32'hDEAD_BEEF;
        if (b_maddr[31:7] == ROM_B[31:7]) b_look = rom_word(b_maddr[6:2]);
        else if (b_maddr[31:7] == RAM_B[31:7]) b_look = ram_b[b_maddr[6:2]];
    end
    assign b_mrdata = b_p2;
    always @(posedge clk) begin
        b_p1 <= b_look;
        b_p2 <= b_p1;
        if (a_mwe && a_maddr[31:7] == RAM_B[31:7]) ram_a[a_maddr[6:2]] <= a_mwdata;
        if (b_mwe && b_maddr[31:7] == RAM_B[31:7]) ram_b[b_maddr[6:2]] <= b_mwdata;
    end

    int a_we_cnt = 0;
    always @(negedge clk) if (a_mwe) a_we_cnt++;

    int n_assert = 0;
    int n_fail = 0;
    logic [31:0] ref_ram [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction on instance A with expectations from the address map.
    task automatic a_xact(input bit isif, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag);
        bit aligned, in_rom, in_ram, legal, got;
        int exp_lat, cnt, we0;
        logic [31:0] exp_rd, rd, other;
        logic er;
        aligned = (addr % 4) == 0;
        in_rom  = addr >= ROM_B && addr < ROM_B + 128;
        in_ram  = addr >= RAM_B && addr < RAM_B + 128;
        legal   = aligned && (in_ram || (in_rom && !(we && !isif)));
        exp_lat = !legal ? 1 : (we && !isif) ? 2 : 2;
        exp_rd  = 0;
        if (legal && !(we && !isif))
            exp_rd = in_rom ? rom_word(5'((addr - ROM_B) / 4)) : ref_ram[(addr - RAM_B) / 4];
        we0 = a_we_cnt;
        if (isif) begin a_if_req = 1; a_if_addr = addr; end
        else begin a_d_req = 1; a_d_we = we; a_d_addr = addr; a_d_wdata = wd; end
        cnt = 0; got = 0; rd = 0; er = 0; other = 0;
        while (!got && cnt < 20) begin
            @(posedge clk); cnt++; #1;
            if (isif ? a_if_ack : a_d_ack) begin
                got = 1;
                rd = isif ? a_if_rdata : a_d_rdata;
                er = isif ? a_if_err : a_d_err;
                other = {31'd0, isif ? a_d_ack : a_if_ack};
            end else if (cnt == 1) begin
                // Inputs change after the grant; only the latched copy may matter.
                if (isif) a_if_addr = $urandom;
                else begin a_d_addr = $urandom; a_d_wdata = $urandom; a_d_we = ~we; end
            end
        end
        a_if_req = 0; a_d_req = 0;
        check({tag, " latency"}, cnt, exp_lat);
        check({tag, " rdata"}, rd, exp_rd);
        check({tag, " err"}, {31'd0, er}, {31'd0, !legal});
        check({tag, " other_ack"}, other, 0);
        check({tag, " we_pulses"}, a_we_cnt - we0, (legal && we && !isif) ? 1 : 0);
        if (legal && we && !isif) ref_ram[(addr - RAM_B) / 4] = wd;
        @(posedge clk); #1;
    endtask

    task automatic b_xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rd, input string tag);
        int cnt;
        bit got;
        logic [31:0] rd;
        b_d_req = 1; b_d_we = we; b_d_addr = addr; b_d_wdata = wd;
        cnt = 0; got = 0; rd = 0;
        while (!got && cnt < 20) begin
            @(posedge clk); cnt++; #1;
            if (b_d_ack) begin got = 1; rd = b_d_rdata; end
        end
        b_d_req = 0;
        check({tag, " latency"}, cnt, exp_lat);
        check({tag, " rdata"}, rd, exp_rd);
        @(posedge clk); #1;
    endtask

    initial begin
        int order[$];
        int acks, k, kind;
        bit if_re, d_re;
        logic [31:0] addr;
        for (int i = 0; i < 32; i++) ref_ram[i] = 0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst if_ack", {31'd0, a_if_ack}, 0);
        check("rst d_ack", {31'd0, a_d_ack}, 0);
        check("rst d_err", {31'd0, a_d_err}, 0);
        check("rst mem_addr", a_maddr, 0);
        check("rst mem_we", {31'd0, a_mwe}, 0);
        check("rst d_rdata", a_d_rdata, 0);
        reset = 0;
        @(posedge clk); #1;

        a_xact(1, 0, 32'h0040_0004, 0, "fetch rom1");
        a_xact(0, 1, 32'h1001_0008, 32'h1234_5678, "store");
        a_xact(0, 0, 32'h1001_0008, 0, "load back");
        a_xact(0, 1, 32'h0040_0000, 32'hFFFF_FFFF, "rom store");
        a_xact(0, 0, 32'h1001_0002, 0, "misaligned");
        a_xact(0, 0, 32'h2000_0000, 0, "unmapped");

        // Reset during the ACCESS cycle of a store
        a_d_req = 1; a_d_we = 1; a_d_addr = 32'h1001_000C; a_d_wdata = 32'h55AA_55AA;
        @(posedge clk); #1;
        check("midrst we before", {31'd0, a_mwe}, 1);
        reset = 1;
        @(posedge clk); #1;
        check("midrst we", {31'd0, a_mwe}, 0);
        check("midrst addr", a_maddr, 0);
        check("midrst wdata", a_mwdata, 0);
        check("midrst acks", {30'd0, a_d_ack, a_if_ack}, 0);
        reset = 0; a_d_req = 0;
        ref_ram[3] = 32'h55AA_55AA;
        acks = 0;
        repeat (6) begin @(posedge clk); #1; if (a_d_ack || a_if_ack) acks++; end
        check("midrst no ack", acks, 0);
        a_xact(1, 0, 32'h0040_0010, 0, "fetch after rst");

        // Both requesters held: grants must alternate starting with fetch
        reset = 1; @(posedge clk); #1; reset = 0;
        a_if_req = 1; a_if_addr = 32'h0040_0008;
        a_d_req = 1; a_d_we = 0; a_d_addr = 32'h1001_0008;
        if_re = 0; d_re = 0; k = 0;
        while (order.size() < 4 && k < 60) begin
            @(posedge clk); k++; #1;
            if (if_re) begin a_if_req = 1; if_re = 0; end
            if (d_re) begin a_d_req = 1; d_re = 0; end
            if (a_if_ack) begin
                order.push_back(0);
                check("rr if data", a_if_rdata, rom_word(5'd2));
                a_if_req = 0; if_re = 1;
            end
            if (a_d_ack) begin
                order.push_back(1);
                check("rr d data", a_d_rdata, 32'h1234_5678);
                a_d_req = 0; d_re = 1;
            end
        end
        a_if_req = 0; a_d_req = 0;
        check("rr ack count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) check($sformatf("rr grant %0d", i), order[i], i % 2);
        repeat (3) @(posedge clk);
        #1;

        // READ_LATENCY = 3 instance
        b_xact(1, 32'h1001_0000, 32'hCAFE_F00D, 2, 0, "L3 store");
        b_xact(0, 32'h1001_0000, 0, 4, 32'hCAFE_F00D, "L3 load");
        b_xact(0, 32'h0040_0014, 0, 4, rom_word(5'd5), "L3 rom load");

        // Randomized traffic against the reference model
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 6);
            case (kind)
                0: a_xact(0, 0, RAM_B + 32'($urandom_range(0, 31)) * 4, 0, "rnd load");
                1: a_xact(0, 1, RAM_B + 32'($urandom_range(0, 31)) * 4, $urandom, "rnd store");
                2: a_xact(1, 0, ROM_B + 32'($urandom_range(0, 31)) * 4, 0, "rnd fetch");
                3: a_xact(0, 1, ROM_B + 32'($urandom_range(0, 31)) * 4, $urandom, "rnd rom store");
                4: begin
                    addr = RAM_B + 32'($urandom_range(0, 127));
                    a_xact(0, $urandom_range(0, 1) == 1, addr, $urandom, "rnd any ram");
                end
                5: a_xact(0, 0, RAM_B + 128 + 32'($urandom_range(0, 31)) * 4, 0, "rnd past ram");
                default: begin
                    addr = $urandom;
                    a_xact($urandom_range(0, 1) == 1, 0, addr, 0, "rnd wild");
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
